// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ssd_pkg
// Purpose  : Shared types, constants and helpers for the seven-segment
//            refresh scheduler (scan geometry, FSM state encoding).
// Revision : 1.0 - initial release
// ============================================================================
package ssd_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int FRAME_W    = NUM_DIGITS * DIGIT_W;
  localparam int SCAN_W     = 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_COMMIT  = 2'd2
  } state_e;

  // A frame boundary is the scan tick that finishes the last digit.
  function automatic logic is_frame_boundary(input logic tick,
                                             input logic [SCAN_W-1:0] scan_idx);
    return tick && (scan_idx == SCAN_W'(NUM_DIGITS - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/ssd_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : ssd_tick_gen
// Purpose  : Prescaler producing the scan tick, plus the scan-position
//            counter and frame-boundary flag. Frozen while en_i is low.
// Revision : 1.0 - initial release
// ============================================================================
module ssd_tick_gen
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  output logic              tick_o,
  output logic              boundary_o,
  output logic [SCAN_W-1:0] scan_idx_o
);

  localparam int               CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic              tick;

  // Next-state for prescaler and scan index; both hold when disabled.
  always_comb begin
    tick   = en_i && (cnt_q == CNT_LAST);
    cnt_d  = cnt_q;
    scan_d = scan_q;
    if (en_i) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
    if (tick) begin
      scan_d = scan_q + 1'b1;
    end
  end

  // Prescaler and scan-index registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      scan_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      scan_q <= scan_d;
    end
  end

  assign tick_o     = tick;
  assign boundary_o = is_frame_boundary(tick, scan_q);
  assign scan_idx_o = scan_q;

endmodule
`default_nettype wire

// File: rtl/ssd_refresh_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ssd_refresh_scheduler
// Purpose  : Shares a 4-digit seven-segment driver between two requesters.
//            Round-robin arbitration with a minimum ownership hold; accepted
//            frames are committed only at a scan-frame boundary (no tearing).
// Revision : 1.0 - initial release
// ============================================================================
module ssd_refresh_scheduler
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV = 4,
  parameter int HOLD_FRAMES = 2
) (
  input  logic                 i_CLK,
  input  logic                 i_RESET_N,
  input  logic                 i_SW_ENABLE,
  input  logic [1:0]           i_REQ_VALID,
  input  logic [2*FRAME_W-1:0] i_REQ_DATA,
  output logic [1:0]           o_REQ_READY,
  output logic                 o_DRIVE_ENABLE,
  output logic [SCAN_W-1:0]    o_SCAN_IDX,
  output logic                 o_DIGIT_WE,
  output logic [FRAME_W-1:0]   o_DIGITS,
  output logic                 o_OWNER
);

  localparam int               HOLD_W    = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_FRAMES);

  state_e             state_q;
  logic [FRAME_W-1:0] shadow_q;
  logic [FRAME_W-1:0] digits_q;
  logic               pend_owner_q;
  logic               owner_q;
  logic               rr_q;
  logic               we_q;
  logic [HOLD_W-1:0]  hold_q, hold_d;

  logic               tick;
  logic               boundary;
  logic [1:0]         elig;
  logic               grant_vld;
  logic               grant_idx;

  ssd_tick_gen #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_tick_gen (
    .clk_i      (i_CLK),
    .rst_ni     (i_RESET_N),
    .en_i       (i_SW_ENABLE),
    .tick_o     (tick),
    .boundary_o (boundary),
    .scan_idx_o (o_SCAN_IDX)
  );

  // Eligibility and round-robin grant; the current owner bypasses the hold.
  always_comb begin
    elig[0]   = i_REQ_VALID[0] && (!owner_q || (hold_q == '0));
    elig[1]   = i_REQ_VALID[1] && ( owner_q || (hold_q == '0));
    grant_vld = (state_q == S_IDLE) && (|elig);
    grant_idx = (&elig) ? rr_q : elig[1];
  end

  // Hold window: count down per frame; a commit reload takes priority.
  always_comb begin
    hold_d = hold_q;
    if (boundary && (hold_q != '0)) begin
      hold_d = hold_q - 1'b1;
    end
    if (state_q == S_COMMIT) begin
      hold_d = HOLD_INIT;
    end
  end

  // Scheduler FSM with registered commit strobe and display registers.
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state_q      <= S_IDLE;
      shadow_q     <= '0;
      digits_q     <= '0;
      pend_owner_q <= 1'b0;
      owner_q      <= 1'b0;
      rr_q         <= 1'b0;
      we_q         <= 1'b0;
      hold_q       <= '0;
    end else begin
      hold_q <= hold_d;
      we_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_vld) begin
            shadow_q     <= grant_idx ? i_REQ_DATA[2*FRAME_W-1:FRAME_W]
                                      : i_REQ_DATA[FRAME_W-1:0];
            pend_owner_q <= grant_idx;
            rr_q         <= ~grant_idx;
            state_q      <= S_PENDING;
          end
        end
        S_PENDING: begin
          if (boundary) begin
            we_q    <= 1'b1;
            state_q <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          digits_q <= shadow_q;
          owner_q  <= pend_owner_q;
          state_q  <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Reset is folded into the combinational outputs so they read 0 at once.
  assign o_REQ_READY    = (i_RESET_N && grant_vld) ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;
  assign o_DRIVE_ENABLE = i_RESET_N && tick;
  assign o_DIGIT_WE     = we_q;
  assign o_DIGITS       = digits_q;
  assign o_OWNER        = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_ssd_refresh_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ssd_refresh_scheduler
// Purpose  : Scoreboard bench. Stimulus pushes hand-computed expected events
//            (scan ticks, grants, commits with cycle numbers); monitors pop
//            and compare whenever the DUTs present them.
//            DUT A: REFRESH_DIV=4, HOLD_FRAMES=2. DUT B: HOLD_FRAMES=0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ssd_refresh_scheduler;

  typedef struct {
    int          cyc;
    logic [15:0] val;
    logic        own;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sw_a;
  logic        sw_b;
  logic [1:0]  a_valid, b_valid;
  logic [31:0] a_data,  b_data;
  logic [1:0]  a_ready, b_ready;
  logic        a_drv,   b_drv;
  logic [1:0]  a_scan,  b_scan;
  logic        a_we,    b_we;
  logic [15:0] a_digits, b_digits;
  logic        a_owner, b_owner;

  int  cyc;
  int  n_pass  = 0;
  int  n_total = 0;
  bit  tick_track = 1'b0;

  ev_t a_tick_q[$], a_gnt_q[$], a_com_q[$], b_gnt_q[$], b_com_q[$];

  always #5 clk = ~clk;

  ssd_refresh_scheduler #(.REFRESH_DIV(4), .HOLD_FRAMES(2)) u_dut_a (
    .i_CLK(clk), .i_RESET_N(rst_n), .i_SW_ENABLE(sw_a),
    .i_REQ_VALID(a_valid), .i_REQ_DATA(a_data), .o_REQ_READY(a_ready),
    .o_DRIVE_ENABLE(a_drv), .o_SCAN_IDX(a_scan), .o_DIGIT_WE(a_we),
    .o_DIGITS(a_digits), .o_OWNER(a_owner)
  );

  ssd_refresh_scheduler #(.REFRESH_DIV(4), .HOLD_FRAMES(0)) u_dut_b (
    .i_CLK(clk), .i_RESET_N(rst_n), .i_SW_ENABLE(sw_b),
    .i_REQ_VALID(b_valid), .i_REQ_DATA(b_data), .o_REQ_READY(b_ready),
    .o_DRIVE_ENABLE(b_drv), .o_SCAN_IDX(b_scan), .o_DIGIT_WE(b_we),
    .o_DIGITS(b_digits), .o_OWNER(b_owner)
  );

  // Cycle number: 0 is the cycle in which reset is released.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic ev_t mk(input int c, input logic [15:0] v, input logic o);
    ev_t e;
    e.cyc = c;
    e.val = v;
    e.own = o;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic unexp(input string nm);
    n_total++;
    $display("FAIL %s: unexpected event at cycle %0d, required none", nm, cyc);
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic send(input int r, input logic [15:0] d);
    int k;
    a_data[r*16 +: 16] = d;
    a_valid[r] = 1'b1;
    k = 0;
    while (k < 200) begin
      @(negedge clk);
      if (a_ready[r]) break;
      k++;
    end
    if (k == 200) begin
      n_total++;
      $display("FAIL send req%0d: no ready after %0d cycles, required accept", r, k);
    end
    @(posedge clk);
    #1;
    a_valid[r] = 1'b0;
  endtask

  // Monitor for DUT A.
  initial begin : mon_a
    ev_t e;
    ev_t last;
    bit  dig_pend;
    dig_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (dig_pend) begin
          chk("A digits after commit", a_digits, last.val);
          chk("A owner after commit", a_owner, last.own);
          dig_pend = 1'b0;
        end
        if (tick_track && a_drv) begin
          if (a_tick_q.size() == 0) unexp("A tick");
          else begin
            e = a_tick_q.pop_front();
            chk("A tick cycle", cyc, e.cyc);
            chk("A tick scan_idx", a_scan, e.val);
          end
        end
        if (|(a_valid & a_ready)) begin
          if (a_gnt_q.size() == 0) unexp("A grant");
          else begin
            e = a_gnt_q.pop_front();
            chk("A grant cycle", cyc, e.cyc);
            chk("A grant ready", a_ready, e.val);
          end
        end
        if (a_we) begin
          if (a_com_q.size() == 0) unexp("A commit");
          else begin
            e = a_com_q.pop_front();
            chk("A commit cycle", cyc, e.cyc);
            last     = e;
            dig_pend = 1'b1;
          end
        end
      end
    end
  end

  // Monitor for DUT B.
  initial begin : mon_b
    ev_t e;
    ev_t last;
    bit  dig_pend;
    dig_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (dig_pend) begin
          chk("B digits after commit", b_digits, last.val);
          chk("B owner after commit", b_owner, last.own);
          dig_pend = 1'b0;
        end
        if (|(b_valid & b_ready)) begin
          if (b_gnt_q.size() == 0) unexp("B grant");
          else begin
            e = b_gnt_q.pop_front();
            chk("B grant cycle", cyc, e.cyc);
            chk("B grant ready", b_ready, e.val);
          end
        end
        if (b_we) begin
          if (b_com_q.size() == 0) unexp("B commit");
          else begin
            e = b_com_q.pop_front();
            chk("B commit cycle", cyc, e.cyc);
            last     = e;
            dig_pend = 1'b1;
          end
        end
      end
    end
  end

  // Stimulus.
  initial begin
    rst_n   = 1'b0;
    sw_a    = 1'b1;
    sw_b    = 1'b1;
    a_valid = 2'b11;
    a_data  = 32'hFFFF_FFFF;
    b_valid = 2'b11;
    b_data  = {16'h5555, 16'hAAAA};

    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", a_ready, 2'b00);
    chk("reset drive_enable", a_drv, 1'b0);
    chk("reset scan_idx", a_scan, 2'd0);
    chk("reset digit_we", a_we, 1'b0);
    chk("reset digits", a_digits, 16'h0);
    chk("reset owner", a_owner, 1'b0);
    a_valid = 2'b00;
    a_data  = '0;

    // Idle scan on A; B alternates owners with no hold.
    a_tick_q.push_back(mk(3, 16'd0, 1'b0));
    a_tick_q.push_back(mk(7, 16'd1, 1'b0));
    a_tick_q.push_back(mk(11, 16'd2, 1'b0));
    a_tick_q.push_back(mk(15, 16'd3, 1'b0));
    b_gnt_q.push_back(mk(0, 16'h1, 1'b0));
    b_gnt_q.push_back(mk(17, 16'h2, 1'b0));
    b_gnt_q.push_back(mk(33, 16'h1, 1'b0));
    b_gnt_q.push_back(mk(49, 16'h2, 1'b0));
    b_com_q.push_back(mk(16, 16'hAAAA, 1'b0));
    b_com_q.push_back(mk(32, 16'h5555, 1'b1));
    b_com_q.push_back(mk(48, 16'hAAAA, 1'b0));
    b_com_q.push_back(mk(64, 16'h5555, 1'b1));
    tick_track = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b1;
    goto(17);
    tick_track = 1'b0;
    goto(65);
    b_valid = 2'b00;
    goto(70);
    chk("A idle digits", a_digits, 16'h0);

    // Single accept, then hold window with owner re-request.
    a_gnt_q.push_back(mk(1, 16'h1, 1'b0));
    a_gnt_q.push_back(mk(20, 16'h1, 1'b0));
    a_gnt_q.push_back(mk(64, 16'h2, 1'b0));
    a_com_q.push_back(mk(16, 16'h1234, 1'b0));
    a_com_q.push_back(mk(32, 16'h0F0F, 1'b0));
    a_com_q.push_back(mk(80, 16'hBEEF, 1'b1));
    do_reset();
    goto(1);
    send(0, 16'h1234);
    goto(17);
    a_data[31:16] = 16'hBEEF;
    a_valid[1]    = 1'b1;
    goto(20);
    send(0, 16'h0F0F);
    send(1, 16'hBEEF);
    goto(85);

    // Enable dropped while a frame is pending.
    a_gnt_q.push_back(mk(1, 16'h1, 1'b0));
    a_com_q.push_back(mk(36, 16'h4321, 1'b0));
    a_tick_q.push_back(mk(3, 16'd0, 1'b0));
    a_tick_q.push_back(mk(7, 16'd1, 1'b0));
    a_tick_q.push_back(mk(31, 16'd2, 1'b0));
    a_tick_q.push_back(mk(35, 16'd3, 1'b0));
    tick_track = 1'b1;
    do_reset();
    goto(1);
    send(0, 16'h4321);
    goto(9);
    sw_a = 1'b0;
    goto(29);
    sw_a = 1'b1;
    goto(37);
    tick_track = 1'b0;

    // Reset asserted while a frame is pending: it must never be committed.
    a_gnt_q.push_back(mk(40, 16'h1, 1'b0));
    goto(40);
    send(0, 16'h7777);
    goto(44);
    chk("A digits before reset", a_digits, 16'h4321);
    a_valid = 2'b01;
    #2 rst_n = 1'b0;
    #1;
    chk("mid reset ready", a_ready, 2'b00);
    chk("mid reset digits", a_digits, 16'h0);
    chk("mid reset digit_we", a_we, 1'b0);
    chk("mid reset scan_idx", a_scan, 2'd0);
    a_valid = 2'b00;
    @(posedge clk);
    #2 rst_n = 1'b1;
    goto(40);
    chk("post reset digits", a_digits, 16'h0);
    chk("post reset owner", a_owner, 1'b0);

    chk("A tick events left", a_tick_q.size(), 0);
    chk("A grant events left", a_gnt_q.size(), 0);
    chk("A commit events left", a_com_q.size(), 0);
    chk("B grant events left", b_gnt_q.size(), 0);
    chk("B commit events left", b_com_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
